// File: rtl/fifo_seq_checker_pkg.sv
// Shared state encoding and sequence helper for fifo_seq_checker.
// Contents: seq_state_t (IDLE/SEARCH/LOCKED), SEQ_MAX_W, next_seq().
package fifo_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } seq_state_t;

    // Widest data word next_seq can handle.
    localparam int SEQ_MAX_W = 64;

    // Successor in the test sequence: +1 within the active width
    // (selected by mask), with 0 skipped so all-ones wraps to 1.
    function automatic logic [SEQ_MAX_W-1:0] next_seq(
        input logic [SEQ_MAX_W-1:0] x,
        input logic [SEQ_MAX_W-1:0] mask
    );
        logic [SEQ_MAX_W-1:0] n;
        n = (x + 64'd1) & mask;
        if (n == '0) begin
            n = 64'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_chk_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Ports: clk, rst (sync, active-high), clr, inc -> count[WIDTH-1:0].
module seq_chk_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_seq_checker.sv
// Read-side checker of the async fifo: drains words and checks that they
// form the incrementing test sequence (0 skipped), reporting lock/counters.
// Ports: clock_out, rst_out (sync, active-high), data_out, data_out_valid,
//   data_out_ack (registered), enable, clr, locked, err_pulse,
//   word_count, err_count. Build macro SEQ_CHK_THROTTLE_EN adds
//   throttle[3:0]: ack high one cycle in every throttle+1.
module fifo_seq_checker
    import fifo_seq_checker_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 16,
    parameter int LOCK_COUNT    = 4,
    parameter int LOSS_COUNT    = 3
) (
    input  logic                     clock_out,
    input  logic                     rst_out,
    input  logic [DATA_WIDTH-1:0]    data_out,
    input  logic                     data_out_valid,
    output logic                     data_out_ack,
    input  logic                     enable,
    input  logic                     clr,
`ifdef SEQ_CHK_THROTTLE_EN
    input  logic [3:0]               throttle,
`endif
    output logic                     locked,
    output logic                     err_pulse,
    output logic [31:0]              word_count,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W = $clog2(LOSS_COUNT + 1);
    localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0] LOSS_LAST = BAD_W'(LOSS_COUNT - 1);
    localparam logic [SEQ_MAX_W-1:0] SEQ_MASK =
        {SEQ_MAX_W{1'b1}} >> (SEQ_MAX_W - DATA_WIDTH);

    seq_state_t            state_q;
    seq_state_t            state_d;
    logic                  seeded_q;
    logic                  seeded_d;
    logic [DATA_WIDTH-1:0] expected_q;
    logic [DATA_WIDTH-1:0] expected_d;
    logic [RUN_W-1:0]      run_q;
    logic [RUN_W-1:0]      run_d;
    logic [BAD_W-1:0]      bad_q;
    logic [BAD_W-1:0]      bad_d;
    logic                  err_inc;

    logic                  xfer;
    logic                  is_match;
    logic                  ack_en;
    logic [DATA_WIDTH-1:0] succ;

    assign xfer     = data_out_valid && data_out_ack;
    assign is_match = (data_out == expected_q);
    assign ack_en   = enable && !clr;
    assign succ     = DATA_WIDTH'(next_seq(SEQ_MAX_W'(data_out), SEQ_MASK));

    // ack is a pure register of the control inputs; never looks at valid.
`ifdef SEQ_CHK_THROTTLE_EN
    logic [3:0] thr_cnt_q;

    always_ff @(posedge clock_out) begin
        if (rst_out || !ack_en) begin
            data_out_ack <= 1'b0;
            thr_cnt_q    <= '0;
        end else if (thr_cnt_q == '0) begin
            data_out_ack <= 1'b1;
            thr_cnt_q    <= throttle;
        end else begin
            data_out_ack <= 1'b0;
            thr_cnt_q    <= thr_cnt_q - 4'd1;
        end
    end
`else
    always_ff @(posedge clock_out) begin
        if (rst_out) begin
            data_out_ack <= 1'b0;
        end else begin
            data_out_ack <= ack_en;
        end
    end
`endif

    // State register
    always_ff @(posedge clock_out) begin
        if (rst_out) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = enable ? ST_SEARCH : ST_IDLE;
        end else if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (xfer && seeded_q && is_match && (run_q == LOCK_LAST)) begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (xfer && !is_match && (bad_q == LOSS_LAST)) begin
                        state_d = ST_SEARCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Tracking datapath: seed, expected word, match/mismatch runs.
    always_comb begin
        seeded_d   = seeded_q;
        expected_d = expected_q;
        run_d      = run_q;
        bad_d      = bad_q;
        err_inc    = 1'b0;
        if (clr || !enable || (state_q == ST_IDLE)) begin
            seeded_d = 1'b0;
            run_d    = '0;
            bad_d    = '0;
        end else if (xfer) begin
            expected_d = succ;
            if (state_q == ST_SEARCH) begin
                seeded_d = 1'b1;
                bad_d    = '0;
                if (seeded_q && is_match && (run_q != LOCK_LAST)) begin
                    run_d = run_q + RUN_W'(1);
                end else begin
                    run_d = '0;
                end
            end else begin
                if (is_match) begin
                    bad_d = '0;
                end else begin
                    err_inc = 1'b1;
                    if (bad_q == LOSS_LAST) begin
                        // Lock lost: this word becomes the new seed.
                        bad_d    = '0;
                        run_d    = '0;
                        seeded_d = 1'b1;
                    end else begin
                        bad_d = bad_q + BAD_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_out) begin
        if (rst_out) begin
            seeded_q   <= 1'b0;
            expected_q <= '0;
            run_q      <= '0;
            bad_q      <= '0;
            err_pulse  <= 1'b0;
            word_count <= '0;
        end else begin
            seeded_q   <= seeded_d;
            expected_q <= expected_d;
            run_q      <= run_d;
            bad_q      <= bad_d;
            err_pulse  <= err_inc;
            if (clr) begin
                word_count <= '0;
            end else if (xfer) begin
                word_count <= word_count + 32'd1;
            end
        end
    end

    seq_chk_sat_counter #(
        .WIDTH (ERR_CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clock_out),
        .rst   (rst_out),
        .clr   (clr),
        .inc   (err_inc),
        .count (err_count)
    );

    // Output logic
    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Self-checking bench for fifo_seq_checker: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_fifo_seq_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;
    localparam int M_IDLE = 0;
    localparam int M_SRCH = 1;
    localparam int M_LOCK = 2;

    logic        clock_out = 1'b0;
    logic        rst_out = 1'b1;
    logic [31:0] data_out = '0;
    logic        data_out_valid = 1'b0;
    logic        data_out_ack;
    logic        enable = 1'b0;
    logic        clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] word_count;
    logic [15:0] err_count;
`ifdef SEQ_CHK_THROTTLE_EN
    logic [3:0]  throttle = 4'd0;
`endif

    fifo_seq_checker dut (
        .clock_out      (clock_out),
        .rst_out        (rst_out),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ack   (data_out_ack),
        .enable         (enable),
        .clr            (clr),
`ifdef SEQ_CHK_THROTTLE_EN
        .throttle       (throttle),
`endif
        .locked         (locked),
        .err_pulse      (err_pulse),
        .word_count     (word_count),
        .err_count      (err_count)
    );

    always #5 clock_out = ~clock_out;

    int cmp = 0;
    int bad = 0;

    // Reference model state
    int          m_mode = M_IDLE;
    bit          m_ack = 1'b0;
    bit          m_seeded = 1'b0;
    bit          m_pulse = 1'b0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_wc = '0;
    logic [15:0] m_ec = '0;
    int          m_run = 0;
    int          m_bad = 0;
    int          m_phase = 0;

    function automatic logic [31:0] succ(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? 32'd1 : x + 32'd1;
    endfunction

    function automatic int thr_val();
`ifdef SEQ_CHK_THROTTLE_EN
        return int'(throttle);
`else
        return 0;
`endif
    endfunction

    // Model evaluation of one clock edge from the inputs present at it.
    task automatic model_edge();
        bit xfer;
        bit ok;
        xfer = data_out_valid && m_ack;
        if (rst_out) begin
            m_mode = M_IDLE; m_ack = 0; m_seeded = 0; m_pulse = 0;
            m_exp = '0; m_wc = '0; m_ec = '0;
            m_run = 0; m_bad = 0; m_phase = 0;
            return;
        end
        m_pulse = 0;
        if (enable && !clr) begin
            m_ack = ((m_phase % (thr_val() + 1)) == 0);
            m_phase++;
        end else begin
            m_ack = 0;
            m_phase = 0;
        end
        if (clr) begin
            m_wc = '0; m_ec = '0;
            m_mode = enable ? M_SRCH : M_IDLE;
            m_seeded = 0; m_run = 0; m_bad = 0;
            return;
        end
        if (xfer) m_wc = m_wc + 32'd1;
        if (!enable) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_SRCH; m_seeded = 0; m_run = 0; m_bad = 0;
        end else if (xfer) begin
            ok = (data_out == m_exp);
            m_exp = succ(data_out);
            if (m_mode == M_SRCH) begin
                if (m_seeded && ok) begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_mode = M_LOCK; m_bad = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_seeded = 1;
            end else if (ok) begin
                m_bad = 0;
            end else begin
                if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
                m_pulse = 1;
                m_bad++;
                if (m_bad == LOSS_N) begin
                    m_mode = M_SRCH; m_run = 0; m_bad = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock_out);
        model_edge();
        #1;
    endtask

    task automatic feed(input logic [31:0] w);
        data_out_valid = 1'b1;
        data_out = w;
        tick();
    endtask

    task automatic test_reset();
        rst_out = 1'b1; enable = 1'b0; data_out_valid = 1'b0;
        tick(); tick();
        cmp++; if (data_out_ack !== 1'b0) begin bad++; $display("FAIL reset.ack got %0b want 0", data_out_ack); end
        cmp++; if (locked !== 1'b0) begin bad++; $display("FAIL reset.locked got %0b want 0", locked); end
        cmp++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset.pulse got %0b want 0", err_pulse); end
        cmp++; if (word_count !== 32'd0) begin bad++; $display("FAIL reset.wc got %0h want 0", word_count); end
        cmp++; if (err_count !== 16'd0) begin bad++; $display("FAIL reset.ec got %0h want 0", err_count); end
        enable = 1'b1; data_out_valid = 1'b1; data_out = 32'd77;
        tick(); tick();
        cmp++; if (data_out_ack !== 1'b0) begin bad++; $display("FAIL reset_held.ack got %0b want 0", data_out_ack); end
        cmp++; if (word_count !== 32'd0) begin bad++; $display("FAIL reset_held.wc got %0h want 0", word_count); end
        enable = 1'b0; data_out_valid = 1'b0;
        rst_out = 1'b0;
        tick();
    endtask

    task automatic test_lock_basic();
        enable = 1'b1; data_out_valid = 1'b0;
        tick();
        cmp++; if (data_out_ack !== 1'b1) begin bad++; $display("FAIL lock.ack got %0b want 1", data_out_ack); end
        for (int i = 1; i <= 5; i++) begin
            feed(32'(i));
            cmp++;
            if (locked !== (i == 5)) begin
                bad++; $display("FAIL lock.locked[%0d] got %0b want %0b", i, locked, (i == 5));
            end
        end
        cmp++; if (err_count !== 16'd0) begin bad++; $display("FAIL lock.ec got %0h want 0", err_count); end
        cmp++; if (word_count !== 32'd5) begin bad++; $display("FAIL lock.wc got %0h want 5", word_count); end
    endtask

    task automatic test_single_error();
        for (int i = 6; i <= 9; i++) begin
            feed(32'(i));
            cmp++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL serr.pulse[%0d] got %0b want 0", i, err_pulse); end
        end
        feed(32'd11);
        cmp++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL serr.pulse11 got %0b want 1", err_pulse); end
        cmp++; if (err_count !== 16'd1) begin bad++; $display("FAIL serr.ec11 got %0h want 1", err_count); end
        cmp++; if (locked !== 1'b1) begin bad++; $display("FAIL serr.locked11 got %0b want 1", locked); end
        feed(32'd12);
        cmp++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL serr.pulse12 got %0b want 0", err_pulse); end
        cmp++; if (err_count !== 16'd1) begin bad++; $display("FAIL serr.ec12 got %0h want 1", err_count); end
        cmp++; if (locked !== 1'b1) begin bad++; $display("FAIL serr.locked12 got %0b want 1", locked); end
        cmp++; if (word_count !== 32'd11) begin bad++; $display("FAIL serr.wc got %0h want 11", word_count); end
    endtask

    task automatic test_loss_relock();
        logic [31:0] junk [3];
        junk[0] = 32'd100; junk[1] = 32'd50; junk[2] = 32'd7;
        for (int i = 0; i < 3; i++) begin
            feed(junk[i]);
            cmp++; if (err_count !== 16'(2 + i)) begin bad++; $display("FAIL loss.ec[%0d] got %0h want %0h", i, err_count, 2 + i); end
            cmp++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL loss.pulse[%0d] got %0b want 1", i, err_pulse); end
            cmp++; if (locked !== (i != 2)) begin bad++; $display("FAIL loss.locked[%0d] got %0b want %0b", i, locked, (i != 2)); end
        end
        for (int i = 8; i <= 11; i++) begin
            feed(32'(i));
            cmp++; if (locked !== (i == 11)) begin bad++; $display("FAIL relock.locked[%0d] got %0b want %0b", i, locked, (i == 11)); end
        end
        cmp++; if (err_count !== 16'd4) begin bad++; $display("FAIL relock.ec got %0h want 4", err_count); end
        cmp++; if (word_count !== 32'd18) begin bad++; $display("FAIL relock.wc got %0h want 18", word_count); end
    endtask

    task automatic test_wrap();
        logic [31:0] w [5];
        w[0] = 32'hFFFF_FFFE; w[1] = 32'hFFFF_FFFF;
        w[2] = 32'd1; w[3] = 32'd2; w[4] = 32'd3;
        clr = 1'b1; data_out_valid = 1'b1; data_out = 32'd13;
        tick();
        clr = 1'b0;
        cmp++; if (word_count !== 32'd0) begin bad++; $display("FAIL clr.wc got %0h want 0", word_count); end
        cmp++; if (err_count !== 16'd0) begin bad++; $display("FAIL clr.ec got %0h want 0", err_count); end
        cmp++; if (locked !== 1'b0) begin bad++; $display("FAIL clr.locked got %0b want 0", locked); end
        cmp++; if (data_out_ack !== 1'b0) begin bad++; $display("FAIL clr.ack got %0b want 0", data_out_ack); end
        data_out_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            feed(w[i]);
            cmp++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL wrap.pulse[%0d] got %0b want 0", i, err_pulse); end
        end
        cmp++; if (locked !== 1'b1) begin bad++; $display("FAIL wrap.locked got %0b want 1", locked); end
        cmp++; if (err_count !== 16'd0) begin bad++; $display("FAIL wrap.ec got %0h want 0", err_count); end
        cmp++; if (word_count !== 32'd5) begin bad++; $display("FAIL wrap.wc got %0h want 5", word_count); end
    endtask

    task automatic test_valid_low_disable();
        data_out_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp++; if (data_out_ack !== 1'b1) begin bad++; $display("FAIL vlow.ack[%0d] got %0b want 1", i, data_out_ack); end
            cmp++; if (word_count !== 32'd5) begin bad++; $display("FAIL vlow.wc[%0d] got %0h want 5", i, word_count); end
        end
        enable = 1'b0; data_out_valid = 1'b1; data_out = 32'd4;
        tick();
        cmp++; if (word_count !== 32'd6) begin bad++; $display("FAIL dis.wc got %0h want 6", word_count); end
        cmp++; if (data_out_ack !== 1'b0) begin bad++; $display("FAIL dis.ack got %0b want 0", data_out_ack); end
        cmp++; if (locked !== 1'b0) begin bad++; $display("FAIL dis.locked got %0b want 0", locked); end
        cmp++; if (err_count !== 16'd0) begin bad++; $display("FAIL dis.ec got %0h want 0", err_count); end
        tick();
        cmp++; if (word_count !== 32'd6) begin bad++; $display("FAIL idle.wc got %0h want 6", word_count); end
        data_out_valid = 1'b0;
    endtask

`ifdef SEQ_CHK_THROTTLE_EN
    task automatic test_throttle();
        int acks;
        acks = 0;
        throttle = 4'd3; enable = 1'b1; clr = 1'b1; data_out_valid = 1'b0;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            feed(32'(i + 1));
            if (data_out_ack === 1'b1) acks++;
        end
        cmp++; if (acks !== 10) begin bad++; $display("FAIL thr.acks got %0d want 10", acks); end
        cmp++; if (word_count !== 32'd10) begin bad++; $display("FAIL thr.wc got %0h want 10", word_count); end
        throttle = 4'd0; clr = 1'b1; data_out_valid = 1'b0;
        tick();
        clr = 1'b0;
        cmp++; if (word_count !== 32'd0) begin bad++; $display("FAIL thr_clr.wc got %0h want 0", word_count); end
        cmp++; if (err_count !== 16'd0) begin bad++; $display("FAIL thr_clr.ec got %0h want 0", err_count); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] g_next;
        bit xfer;
        g_next = 32'd1;
        for (int c = 0; c < 3000; c++) begin
            rst_out = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 39) != 0);
            clr = ($urandom_range(0, 59) == 0);
            data_out_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) data_out = 32'hFFFF_FFFD;
            else if ($urandom_range(0, 14) == 0) data_out = $urandom;
            else data_out = g_next;
            xfer = data_out_valid && m_ack && !rst_out;
            tick();
            if (xfer) g_next = succ(data_out);
            cmp++; if (data_out_ack !== m_ack) begin bad++; $display("FAIL rnd.ack@%0d got %0b want %0b", c, data_out_ack, m_ack); end
            cmp++; if (locked !== (m_mode == M_LOCK)) begin bad++; $display("FAIL rnd.locked@%0d got %0b want %0b", c, locked, (m_mode == M_LOCK)); end
            cmp++; if (err_pulse !== m_pulse) begin bad++; $display("FAIL rnd.pulse@%0d got %0b want %0b", c, err_pulse, m_pulse); end
            cmp++; if (word_count !== m_wc) begin bad++; $display("FAIL rnd.wc@%0d got %0h want %0h", c, word_count, m_wc); end
            cmp++; if (err_count !== m_ec) begin bad++; $display("FAIL rnd.ec@%0d got %0h want %0h", c, err_count, m_ec); end
        end
        rst_out = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_basic();
        test_single_error();
        test_loss_relock();
        test_wrap();
        test_valid_low_disable();
`ifdef SEQ_CHK_THROTTLE_EN
        test_throttle();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
